// File: rtl/tpu_rstation_mq.sv
// Reservation station with three in-order issue queues (tload, tstore, tmma),
// a FENCE that reports the retired-instruction count, and error responses for illegal ops.

module tpu_rs_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int CFG_W = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [1:0]       push_type_i,
    input  logic [XLEN-1:0]  push_addr0_i,
    input  logic [XLEN-1:0]  push_addr1_i,
    input  logic [CFG_W-1:0] push_cfg_i,
    input  logic             rdy_i,
    output logic             vld_o,
    output logic [1:0]       type_o,
    output logic [XLEN-1:0]  addr0_o,
    output logic [XLEN-1:0]  addr1_o,
    output logic [CFG_W-1:0] cfg_o,
    output logic [PTR_W:0]   cnt_o,
    output logic             full_o,
    output logic             pop_o
);
    logic [PTR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]       type_q  [DEPTH];
    logic [1:0]       type_d  [DEPTH];
    logic [XLEN-1:0]  addr0_q [DEPTH];
    logic [XLEN-1:0]  addr0_d [DEPTH];
    logic [XLEN-1:0]  addr1_q [DEPTH];
    logic [XLEN-1:0]  addr1_d [DEPTH];
    logic [CFG_W-1:0] cfg_q   [DEPTH];
    logic [CFG_W-1:0] cfg_d   [DEPTH];
    logic             empty;

    assign empty   = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]) && (wptr_q[PTR_W] != rptr_q[PTR_W]);
    assign vld_o   = !empty;
    assign pop_o   = vld_o && rdy_i;
    assign cnt_o   = wptr_q - rptr_q;
    assign type_o  = type_q[rptr_q[PTR_W-1:0]];
    assign addr0_o = addr0_q[rptr_q[PTR_W-1:0]];
    assign addr1_o = addr1_q[rptr_q[PTR_W-1:0]];
    assign cfg_o   = cfg_q[rptr_q[PTR_W-1:0]];

    // The extra pointer MSB is the wrap bit, so a plain increment handles wrap-around.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        type_d  = type_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        cfg_d   = cfg_q;
        if (push_i) begin
            type_d[wptr_q[PTR_W-1:0]]  = push_type_i;
            addr0_d[wptr_q[PTR_W-1:0]] = push_addr0_i;
            addr1_d[wptr_q[PTR_W-1:0]] = push_addr1_i;
            cfg_d[wptr_q[PTR_W-1:0]]   = push_cfg_i;
            wptr_d = wptr_q + (PTR_W+1)'(1);
        end
        if (pop_o) begin
            rptr_d = rptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        type_q  <= type_d;
        addr0_q <= addr0_d;
        addr1_q <= addr1_d;
        cfg_q   <= cfg_d;
    end
endmodule

module tpu_rstation_mq #(
    parameter int XLEN       = 64,
    parameter int LDQ_DEPTH  = 4,
    parameter int STQ_DEPTH  = 4,
    parameter int MMAQ_DEPTH = 8,
    parameter int CFG_W      = 8,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_vld_i,
    output logic                          req_rdy_o,
    input  logic [31:0]                   req_insn_i,
    input  logic [XLEN-1:0]               req_rs1_i,
    input  logic [XLEN-1:0]               req_rs2_i,
    input  logic [XLEN-1:0]               req_rs3_i,
    output logic                          resp_vld_o,
    input  logic                          resp_rdy_i,
    output logic [XLEN-1:0]               resp_data_o,
    output logic                          ld_vld_o,
    input  logic                          ld_rdy_i,
    output logic [1:0]                    ld_type_o,
    output logic [XLEN-1:0]               ld_addr0_o,
    output logic [XLEN-1:0]               ld_addr1_o,
    output logic [CFG_W-1:0]              ld_cfg_o,
    output logic [$clog2(LDQ_DEPTH):0]    ld_cnt_o,
    output logic                          st_vld_o,
    input  logic                          st_rdy_i,
    output logic [1:0]                    st_type_o,
    output logic [XLEN-1:0]               st_addr0_o,
    output logic [XLEN-1:0]               st_addr1_o,
    output logic [CFG_W-1:0]              st_cfg_o,
    output logic [$clog2(STQ_DEPTH):0]    st_cnt_o,
    output logic                          mma_vld_o,
    input  logic                          mma_rdy_i,
    output logic [1:0]                    mma_type_o,
    output logic [XLEN-1:0]               mma_addr0_o,
    output logic [XLEN-1:0]               mma_addr1_o,
    output logic [CFG_W-1:0]              mma_cfg_o,
    output logic [$clog2(MMAQ_DEPTH):0]   mma_cnt_o
);
    logic [2:0]       func3;
    logic             is_ld, is_st, is_mma, is_fence;
    logic [1:0]       mma_type;
    logic             accept;
    logic             ld_full, st_full, mma_full;
    logic             ld_pop, st_pop, mma_pop;
    logic             all_empty;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             resp_vld_q, resp_vld_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    logic             unused_bits;

    assign func3       = req_insn_i[14:12];
    assign unused_bits = ^{req_insn_i[31:15], req_insn_i[11:0], req_rs3_i[XLEN-1:CFG_W]};
    assign all_empty   = (ld_cnt_o == '0) && (st_cnt_o == '0) && (mma_cnt_o == '0);

    // Ready depends on the decoded op; it only looks at registered fullness,
    // so a same-cycle pop never makes room for the same-cycle push.
    always_comb begin
        is_ld     = 1'b0;
        is_st     = 1'b0;
        is_mma    = 1'b0;
        is_fence  = 1'b0;
        mma_type  = 2'd0;
        req_rdy_o = !resp_vld_q;
        case (func3)
            3'd0: begin is_ld  = 1'b1; req_rdy_o = !ld_full;  end
            3'd1: begin is_mma = 1'b1; mma_type = 2'd0; req_rdy_o = !mma_full; end
            3'd2: begin is_mma = 1'b1; mma_type = 2'd1; req_rdy_o = !mma_full; end
            3'd3: begin is_mma = 1'b1; mma_type = 2'd2; req_rdy_o = !mma_full; end
            3'd4: begin is_mma = 1'b1; mma_type = 2'd3; req_rdy_o = !mma_full; end
            3'd5: begin is_st  = 1'b1; req_rdy_o = !st_full;  end
            3'd6: begin is_fence = 1'b1; req_rdy_o = all_empty && !resp_vld_q; end
            default: req_rdy_o = !resp_vld_q;
        endcase
    end

    assign accept = req_vld_i && req_rdy_o;

    tpu_rs_queue #(.DEPTH(LDQ_DEPTH), .XLEN(XLEN), .CFG_W(CFG_W)) u_ldq (
        .clk(clk), .rst(rst), .push_i(accept && is_ld), .push_type_i(2'd0),
        .push_addr0_i(req_rs1_i), .push_addr1_i(req_rs2_i), .push_cfg_i(req_rs3_i[CFG_W-1:0]),
        .rdy_i(ld_rdy_i), .vld_o(ld_vld_o), .type_o(ld_type_o), .addr0_o(ld_addr0_o),
        .addr1_o(ld_addr1_o), .cfg_o(ld_cfg_o), .cnt_o(ld_cnt_o), .full_o(ld_full), .pop_o(ld_pop)
    );

    tpu_rs_queue #(.DEPTH(STQ_DEPTH), .XLEN(XLEN), .CFG_W(CFG_W)) u_stq (
        .clk(clk), .rst(rst), .push_i(accept && is_st), .push_type_i(2'd0),
        .push_addr0_i(req_rs1_i), .push_addr1_i(req_rs2_i), .push_cfg_i(req_rs3_i[CFG_W-1:0]),
        .rdy_i(st_rdy_i), .vld_o(st_vld_o), .type_o(st_type_o), .addr0_o(st_addr0_o),
        .addr1_o(st_addr1_o), .cfg_o(st_cfg_o), .cnt_o(st_cnt_o), .full_o(st_full), .pop_o(st_pop)
    );

    tpu_rs_queue #(.DEPTH(MMAQ_DEPTH), .XLEN(XLEN), .CFG_W(CFG_W)) u_mmaq (
        .clk(clk), .rst(rst), .push_i(accept && is_mma), .push_type_i(mma_type),
        .push_addr0_i(req_rs1_i), .push_addr1_i(req_rs2_i), .push_cfg_i(req_rs3_i[CFG_W-1:0]),
        .rdy_i(mma_rdy_i), .vld_o(mma_vld_o), .type_o(mma_type_o), .addr0_o(mma_addr0_o),
        .addr1_o(mma_addr1_o), .cfg_o(mma_cfg_o), .cnt_o(mma_cnt_o), .full_o(mma_full), .pop_o(mma_pop)
    );

    // FENCE and ILLEGAL are only accepted while the response slot is free,
    // so a new response never collides with a pending one.
    always_comb begin
        issued_d    = issued_q + CNT_W'(ld_pop) + CNT_W'(st_pop) + CNT_W'(mma_pop);
        resp_vld_d  = resp_vld_q;
        resp_data_d = resp_data_q;
        if (resp_vld_q && resp_rdy_i) begin
            resp_vld_d = 1'b0;
        end
        if (accept && is_fence) begin
            resp_vld_d  = 1'b1;
            resp_data_d = XLEN'(issued_q);
        end else if (accept && (func3 == 3'd7)) begin
            resp_vld_d  = 1'b1;
            resp_data_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q    <= '0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            issued_q    <= issued_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign resp_vld_o  = resp_vld_q;
    assign resp_data_o = resp_data_q;
endmodule

// File: tb/tb_tpu_rstation_mq.sv
// Scenario tasks plus a randomized run against a queue-based reference model.
module tb_tpu_rstation_mq;
    localparam int XLEN = 64, LDQ = 4, STQ = 4, MMAQ = 8, CFG_W = 8, CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_vld_i = 1'b0;
    logic             req_rdy_o;
    logic [31:0]      req_insn_i = '0;
    logic [XLEN-1:0]  req_rs1_i = '0, req_rs2_i = '0, req_rs3_i = '0;
    logic             resp_vld_o;
    logic             resp_rdy_i = 1'b0;
    logic [XLEN-1:0]  resp_data_o;
    logic             ld_vld_o, st_vld_o, mma_vld_o;
    logic             ld_rdy_i = 1'b0, st_rdy_i = 1'b0, mma_rdy_i = 1'b0;
    logic [1:0]       ld_type_o, st_type_o, mma_type_o;
    logic [XLEN-1:0]  ld_addr0_o, ld_addr1_o, st_addr0_o, st_addr1_o, mma_addr0_o, mma_addr1_o;
    logic [CFG_W-1:0] ld_cfg_o, st_cfg_o, mma_cfg_o;
    logic [2:0]       ld_cnt_o, st_cnt_o;
    logic [3:0]       mma_cnt_o;

    int checks = 0;
    int failures = 0;

    tpu_rstation_mq #(.XLEN(XLEN), .LDQ_DEPTH(LDQ), .STQ_DEPTH(STQ), .MMAQ_DEPTH(MMAQ),
                      .CFG_W(CFG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_insn_i(req_insn_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rs3_i(req_rs3_i),
        .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i), .resp_data_o(resp_data_o),
        .ld_vld_o(ld_vld_o), .ld_rdy_i(ld_rdy_i), .ld_type_o(ld_type_o), .ld_addr0_o(ld_addr0_o),
        .ld_addr1_o(ld_addr1_o), .ld_cfg_o(ld_cfg_o), .ld_cnt_o(ld_cnt_o),
        .st_vld_o(st_vld_o), .st_rdy_i(st_rdy_i), .st_type_o(st_type_o), .st_addr0_o(st_addr0_o),
        .st_addr1_o(st_addr1_o), .st_cfg_o(st_cfg_o), .st_cnt_o(st_cnt_o),
        .mma_vld_o(mma_vld_o), .mma_rdy_i(mma_rdy_i), .mma_type_o(mma_type_o), .mma_addr0_o(mma_addr0_o),
        .mma_addr1_o(mma_addr1_o), .mma_cfg_o(mma_cfg_o), .mma_cnt_o(mma_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: one FIFO per channel, a retired counter and a response slot.
    typedef struct {
        logic [1:0]       typ;
        logic [XLEN-1:0]  a0;
        logic [XLEN-1:0]  a1;
        logic [CFG_W-1:0] cfg;
    } ent_t;

    ent_t            m_ld[$], m_st[$], m_mma[$];
    logic [CNT_W-1:0] m_issued = '0;
    logic             m_resp_vld = 1'b0;
    logic [XLEN-1:0]  m_resp_data = '0;

    function automatic bit m_ready(input logic [2:0] f3);
        case (f3)
            3'd0:                   return m_ld.size() < LDQ;
            3'd5:                   return m_st.size() < STQ;
            3'd1, 3'd2, 3'd3, 3'd4: return m_mma.size() < MMAQ;
            3'd6:                   return (m_ld.size() == 0) && (m_st.size() == 0) && (m_mma.size() == 0) && !m_resp_vld;
            default:                return !m_resp_vld;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0] f3;
        bit acc, pl, ps, pm;
        ent_t e;
        f3 = req_insn_i[14:12];
        if (rst) begin
            m_ld.delete(); m_st.delete(); m_mma.delete();
            m_issued = '0; m_resp_vld = 1'b0; m_resp_data = '0;
            return;
        end
        acc = req_vld_i && m_ready(f3);
        pl = ld_rdy_i && (m_ld.size() > 0);
        ps = st_rdy_i && (m_st.size() > 0);
        pm = mma_rdy_i && (m_mma.size() > 0);
        if (m_resp_vld && resp_rdy_i) m_resp_vld = 1'b0;
        if (acc && f3 == 3'd6) begin m_resp_vld = 1'b1; m_resp_data = XLEN'(m_issued); end
        if (acc && f3 == 3'd7) begin m_resp_vld = 1'b1; m_resp_data = '1; end
        if (pl) void'(m_ld.pop_front());
        if (ps) void'(m_st.pop_front());
        if (pm) void'(m_mma.pop_front());
        m_issued = m_issued + CNT_W'(pl) + CNT_W'(ps) + CNT_W'(pm);
        e.a0 = req_rs1_i; e.a1 = req_rs2_i; e.cfg = req_rs3_i[CFG_W-1:0]; e.typ = 2'd0;
        if (acc && f3 == 3'd0) m_ld.push_back(e);
        if (acc && f3 == 3'd5) m_st.push_back(e);
        if (acc && f3 >= 3'd1 && f3 <= 3'd4) begin e.typ = 2'(f3 - 3'd1); m_mma.push_back(e); end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[14:12] = f3;
        return r;
    endfunction

    task automatic drive_req(input logic [2:0] f3, input logic [XLEN-1:0] a0);
        req_vld_i  = 1'b1;
        req_insn_i = mk_insn(f3);
        req_rs1_i  = a0;
        req_rs2_i  = {$urandom, $urandom};
        req_rs3_i  = {$urandom, $urandom};
    endtask

    task automatic push_op(input logic [2:0] f3, input logic [XLEN-1:0] a0);
        drive_req(f3, a0);
        cycle();
        req_vld_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++; if ({ld_vld_o, st_vld_o, mma_vld_o} !== 3'b000) begin failures++; $display("FAIL reset_vld: got %b expected 000", {ld_vld_o, st_vld_o, mma_vld_o}); end
        checks++; if ({ld_cnt_o, st_cnt_o, mma_cnt_o} !== 10'd0) begin failures++; $display("FAIL reset_cnt: got %h expected 0", {ld_cnt_o, st_cnt_o, mma_cnt_o}); end
        checks++; if (resp_vld_o !== 1'b0 || resp_data_o !== '0) begin failures++; $display("FAIL reset_resp: got vld=%b data=%h expected 0/0", resp_vld_o, resp_data_o); end
    endtask

    task automatic test_ld_basic();
        for (int i = 1; i <= 3; i++) push_op(3'd0, 64'(i * 16));
        checks++; if (ld_cnt_o !== 3'd3) begin failures++; $display("FAIL ld_cnt3: got %0d expected 3", ld_cnt_o); end
        checks++; if (ld_vld_o !== 1'b1 || ld_addr0_o !== 64'h10) begin failures++; $display("FAIL ld_head: got vld=%b addr=%h expected 1/10", ld_vld_o, ld_addr0_o); end
        ld_rdy_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ld_vld_o !== 1'b1 || ld_addr0_o !== 64'((k + 1) * 16)) begin failures++; $display("FAIL ld_issue_order: got vld=%b addr=%h expected 1/%h", ld_vld_o, ld_addr0_o, (k + 1) * 16); end
            cycle();
        end
        ld_rdy_i = 1'b0;
        checks++; if (ld_vld_o !== 1'b0 || ld_cnt_o !== 3'd0) begin failures++; $display("FAIL ld_drained: got vld=%b cnt=%0d expected 0/0", ld_vld_o, ld_cnt_o); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 4; i++) push_op(3'd0, 64'h100 + 64'(i));
        drive_req(3'd0, 64'hDEAD);
        #1;
        checks++; if (req_rdy_o !== 1'b0) begin failures++; $display("FAIL ld_full_rdy: got %b expected 0", req_rdy_o); end
        cycle();
        checks++; if (ld_cnt_o !== 3'd4) begin failures++; $display("FAIL ld_full_cnt: got %0d expected 4", ld_cnt_o); end
        drive_req(3'd2, 64'h200);
        #1;
        checks++; if (req_rdy_o !== 1'b1) begin failures++; $display("FAIL mma_while_ld_full_rdy: got %b expected 1", req_rdy_o); end
        cycle();
        req_vld_i = 1'b0;
        checks++; if (mma_cnt_o !== 4'd1 || mma_type_o !== 2'd1) begin failures++; $display("FAIL mma_tmma: got cnt=%0d type=%0d expected 1/1", mma_cnt_o, mma_type_o); end
        for (int j = 0; j < 5; j++) begin
            ld_rdy_i = 1'b1;
            cycle();
            ld_rdy_i = 1'b0;
            drive_req(3'd0, 64'h104 + 64'(j));
            #1;
            checks++; if (req_rdy_o !== 1'b1) begin failures++; $display("FAIL ld_after_pop_rdy: got %b expected 1", req_rdy_o); end
            cycle();
            req_vld_i = 1'b0;
        end
        ld_rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (ld_addr0_o !== 64'h105 + 64'(k)) begin failures++; $display("FAIL ld_wrap_order: got %h expected %h", ld_addr0_o, 64'h105 + 64'(k)); end
            cycle();
        end
        ld_rdy_i = 1'b0;
        checks++; if (ld_vld_o !== 1'b0) begin failures++; $display("FAIL ld_wrap_empty: got %b expected 0", ld_vld_o); end
    endtask

    task automatic test_back_to_back();
        ld_rdy_i = 1'b1;
        drive_req(3'd0, 64'h55);
        #1;
        checks++; if (ld_vld_o !== 1'b0) begin failures++; $display("FAIL no_bypass: got %b expected 0", ld_vld_o); end
        cycle();
        req_vld_i = 1'b0;
        checks++; if (ld_vld_o !== 1'b1 || ld_addr0_o !== 64'h55) begin failures++; $display("FAIL next_cycle_vld: got vld=%b addr=%h expected 1/55", ld_vld_o, ld_addr0_o); end
        cycle();
        ld_rdy_i = 1'b0;
        checks++; if (ld_vld_o !== 1'b0) begin failures++; $display("FAIL single_pop: got %b expected 0", ld_vld_o); end
        for (int i = 0; i < 4; i++) push_op(3'd0, 64'h300 + 64'(i));
        ld_rdy_i = 1'b1;
        drive_req(3'd0, 64'h399);
        #1;
        checks++; if (req_rdy_o !== 1'b0) begin failures++; $display("FAIL full_push_pop_rdy: got %b expected 0", req_rdy_o); end
        cycle();
        req_vld_i = 1'b0;
        ld_rdy_i = 1'b0;
        checks++; if (ld_cnt_o !== 3'd3) begin failures++; $display("FAIL full_push_pop_cnt: got %0d expected 3", ld_cnt_o); end
        ld_rdy_i = 1'b1;
        repeat (3) cycle();
        ld_rdy_i = 1'b0;
    endtask

    task automatic test_fence();
        rst = 1'b1; cycle(); rst = 1'b0;
        push_op(3'd0, 64'h1); push_op(3'd0, 64'h2); push_op(3'd5, 64'h3);
        push_op(3'd1, 64'h4); push_op(3'd2, 64'h5);
        ld_rdy_i = 1'b1; st_rdy_i = 1'b1; mma_rdy_i = 1'b1;
        cycle();
        mma_rdy_i = 1'b0;
        cycle();
        ld_rdy_i = 1'b0; st_rdy_i = 1'b0;
        checks++; if ({ld_cnt_o, st_cnt_o, mma_cnt_o} !== {3'd0, 3'd0, 4'd1}) begin failures++; $display("FAIL fence_setup_cnt: got %h expected 001", {ld_cnt_o, st_cnt_o, mma_cnt_o}); end
        drive_req(3'd6, 64'h0);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (req_rdy_o !== 1'b0) begin failures++; $display("FAIL fence_blocked: got %b expected 0", req_rdy_o); end
            cycle();
        end
        mma_rdy_i = 1'b1;
        #1;
        checks++; if (req_rdy_o !== 1'b0) begin failures++; $display("FAIL fence_same_cycle_pop: got %b expected 0", req_rdy_o); end
        cycle();
        mma_rdy_i = 1'b0;
        #1;
        checks++; if (req_rdy_o !== 1'b1) begin failures++; $display("FAIL fence_rdy_drained: got %b expected 1", req_rdy_o); end
        cycle();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_rdy_o !== 1'b0) begin failures++; $display("FAIL fence_second_blocked: got %b expected 0", req_rdy_o); end
            cycle();
            checks++; if (resp_vld_o !== 1'b1 || resp_data_o !== 64'd5) begin failures++; $display("FAIL fence_resp: got vld=%b data=%h expected 1/5", resp_vld_o, resp_data_o); end
        end
        req_vld_i = 1'b0;
        resp_rdy_i = 1'b1;
        cycle();
        resp_rdy_i = 1'b0;
        checks++; if (resp_vld_o !== 1'b0) begin failures++; $display("FAIL fence_resp_clear: got %b expected 0", resp_vld_o); end
    endtask

    task automatic test_illegal();
        push_op(3'd5, 64'h77);
        drive_req(3'd7, 64'h0);
        #1;
        checks++; if (req_rdy_o !== 1'b1) begin failures++; $display("FAIL illegal_rdy: got %b expected 1", req_rdy_o); end
        cycle();
        checks++; if (resp_vld_o !== 1'b1 || resp_data_o !== {XLEN{1'b1}}) begin failures++; $display("FAIL illegal_resp: got vld=%b data=%h expected 1/all ones", resp_vld_o, resp_data_o); end
        checks++; if ({ld_cnt_o, st_cnt_o, mma_cnt_o} !== {3'd0, 3'd1, 4'd0}) begin failures++; $display("FAIL illegal_counts: got %h expected 010", {ld_cnt_o, st_cnt_o, mma_cnt_o}); end
        #1;
        checks++; if (req_rdy_o !== 1'b0) begin failures++; $display("FAIL illegal_pending_rdy: got %b expected 0", req_rdy_o); end
        req_vld_i = 1'b0;
        resp_rdy_i = 1'b1;
        cycle();
        resp_rdy_i = 1'b0;
        checks++; if (resp_vld_o !== 1'b0) begin failures++; $display("FAIL illegal_clear: got %b expected 0", resp_vld_o); end
    endtask

    task automatic test_reset_mid();
        push_op(3'd0, 64'h11); push_op(3'd4, 64'h22); push_op(3'd7, 64'h0);
        checks++; if ({ld_vld_o, st_vld_o, mma_vld_o, resp_vld_o} !== 4'b1111) begin failures++; $display("FAIL mid_setup: got %b expected 1111", {ld_vld_o, st_vld_o, mma_vld_o, resp_vld_o}); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if ({ld_cnt_o, st_cnt_o, mma_cnt_o} !== 10'd0) begin failures++; $display("FAIL mid_rst_cnt: got %h expected 0", {ld_cnt_o, st_cnt_o, mma_cnt_o}); end
        checks++; if ({ld_vld_o, st_vld_o, mma_vld_o, resp_vld_o} !== 4'b0000) begin failures++; $display("FAIL mid_rst_vld: got %b expected 0000", {ld_vld_o, st_vld_o, mma_vld_o, resp_vld_o}); end
        push_op(3'd6, 64'h0);
        checks++; if (resp_vld_o !== 1'b1 || resp_data_o !== 64'd0) begin failures++; $display("FAIL mid_rst_counter: got vld=%b data=%h expected 1/0", resp_vld_o, resp_data_o); end
        resp_rdy_i = 1'b1;
        cycle();
        resp_rdy_i = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 79) == 0);
            req_vld_i  = ($urandom_range(0, 3) != 0);
            req_insn_i = mk_insn(3'($urandom_range(0, 7)));
            req_rs1_i  = {$urandom, $urandom};
            req_rs2_i  = {$urandom, $urandom};
            req_rs3_i  = {$urandom, $urandom};
            ld_rdy_i   = ($urandom_range(0, 2) == 0);
            st_rdy_i   = ($urandom_range(0, 2) == 0);
            mma_rdy_i  = ($urandom_range(0, 2) == 0);
            resp_rdy_i = ($urandom_range(0, 1) == 0);
            #1;
            checks++; if (req_rdy_o !== m_ready(req_insn_i[14:12])) begin failures++; $display("FAIL rnd_req_rdy: got %b expected %b", req_rdy_o, m_ready(req_insn_i[14:12])); end
            cycle();
            checks++; if (ld_cnt_o !== 3'(m_ld.size()) || st_cnt_o !== 3'(m_st.size()) || mma_cnt_o !== 4'(m_mma.size()))
                begin failures++; $display("FAIL rnd_cnt: got %0d/%0d/%0d expected %0d/%0d/%0d", ld_cnt_o, st_cnt_o, mma_cnt_o, m_ld.size(), m_st.size(), m_mma.size()); end
            checks++; if (resp_vld_o !== m_resp_vld || resp_data_o !== m_resp_data) begin failures++; $display("FAIL rnd_resp: got %b/%h expected %b/%h", resp_vld_o, resp_data_o, m_resp_vld, m_resp_data); end
            if (m_ld.size() > 0) begin
                checks++; if (ld_vld_o !== 1'b1 || {ld_type_o, ld_addr0_o, ld_addr1_o, ld_cfg_o} !== {m_ld[0].typ, m_ld[0].a0, m_ld[0].a1, m_ld[0].cfg})
                    begin failures++; $display("FAIL rnd_ld_head: got %b %h %h expected %h %h", ld_vld_o, ld_addr0_o, ld_addr1_o, m_ld[0].a0, m_ld[0].a1); end
            end
            if (m_st.size() > 0) begin
                checks++; if (st_vld_o !== 1'b1 || {st_type_o, st_addr0_o, st_addr1_o, st_cfg_o} !== {m_st[0].typ, m_st[0].a0, m_st[0].a1, m_st[0].cfg})
                    begin failures++; $display("FAIL rnd_st_head: got %b %h %h expected %h %h", st_vld_o, st_addr0_o, st_addr1_o, m_st[0].a0, m_st[0].a1); end
            end
            if (m_mma.size() > 0) begin
                checks++; if (mma_vld_o !== 1'b1 || {mma_type_o, mma_addr0_o, mma_addr1_o, mma_cfg_o} !== {m_mma[0].typ, m_mma[0].a0, m_mma[0].a1, m_mma[0].cfg})
                    begin failures++; $display("FAIL rnd_mma_head: got %b t=%0d %h expected t=%0d %h", mma_vld_o, mma_type_o, mma_addr0_o, m_mma[0].typ, m_mma[0].a0); end
            end
        end
        rst = 1'b0;
        req_vld_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ld_basic();
        test_full_wrap();
        test_back_to_back();
        test_fence();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tpu_rstation_mq.md
Name: tpu_rstation_mq

Overview:
- Parametrised successor of the single-queue TPU reservation station.
- Decodes coprocessor requests from the CPU and routes them into three independent in-order issue queues: tload, tstore and tmma (preloadc/tmma/poststorec/preloada).
- Adds a FENCE op that drains all queues and answers on the response channel with a retired-instruction count.
- Illegal func3 values get an error response instead of being silently dropped.

Parameters:
- XLEN, 64, width of rs1/rs2/rs3 and response data.
- LDQ_DEPTH, 4, tload queue entries; power of 2, ≥2.
- STQ_DEPTH, 4, tstore queue entries; power of 2, ≥2.
- MMAQ_DEPTH, 8, tmma queue entries; power of 2, ≥2.
- CFG_W, 8, number of rs3 LSBs stored per entry as cfg.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_vld_i  in  1  CPU request valid.
- req_rdy_o  out  1  request ready.
- req_insn_i  in  32  instruction; func3 = insn[14:12].
- req_rs1_i / req_rs2_i / req_rs3_i  in  XLEN each  operand data.
- resp_vld_o  out  1  response valid.
- resp_rdy_i  in  1  response ready.
- resp_data_o  out  XLEN  response data.
- For each channel X in {ld, st, mma}:
  - X_vld_o  out  1  issue valid.
  - X_rdy_i  in  1  issue ready.
  - X_type_o  out  2  entry type.
  - X_addr0_o  out  XLEN  entry addr0 (from rs1).
  - X_addr1_o  out  XLEN  entry addr1 (from rs2).
  - X_cfg_o  out  CFG_W  entry cfg (rs3[CFG_W-1:0]).
- X_cnt_o  out  $clog2(DEPTH)+1  current occupancy of queue X.

Behaviour:
- Reset: clk and rst are fixed as above (one clock; synchronous, active-high reset). On rst=1 at a rising edge:
  - all pointers, wrap bits and counts go to 0;
  - resp_vld_o=0, resp_data_o=0;
  - all X_vld_o=0;
  - issued counter = 0.
  - Entry payloads are not reset.
  - rst mid-operation discards queued entries and any pending response with no further handshakes.
- func3 decode:
  - 0 TLOAD → ld queue, type 0.
  - 1 PRELOADC → mma queue, type 0.
  - 2 TMMA → mma queue, type 1.
  - 3 POSTSTOREC → mma queue, type 2.
  - 4 PRELOADA → mma queue, type 3.
  - 5 TSTORE → st queue, type 0.
  - 6 FENCE.
  - 7 ILLEGAL.
- req_rdy_o is combinational from req_insn_i and state; it may depend on insn:
  - queue op: target queue not full;
  - FENCE: all three counts==0 AND resp_vld_o==0;
  - ILLEGAL: resp_vld_o==0.
- Accept = req_vld_i & req_rdy_o.
- A pop in the same cycle never frees space for the same-cycle push; ready is based on registered full only.
- Queues:
  - circular buffer with PTR_W=$clog2(DEPTH) index plus wrap bit;
  - full = indices equal and wrap bits differ; empty = pointers fully equal.
  - Push writes the entry at wptr and advances it; index wraps DEPTH-1→0 and toggles the wrap bit.
  - X_vld_o = !empty, registered (no bypass): an entry pushed in cycle N is first visible in cycle N+1.
  - Head fields are driven from the rptr entry; issue handshake X_vld_o&X_rdy_i advances rptr.
  - Simultaneous push and pop on the same queue: count unchanged, both pointers advance.
  - Outputs stay stable while X_vld_o=1 and X_rdy_i=0.
- Issued counter:
  - increments by the number of issue handshakes in the cycle (0–3 across the three channels);
  - wraps mod 2^CNT_W.
- Response, single register:
  - FENCE accept in cycle N → resp_vld_o=1 in N+1 with resp_data_o = zero-extended issued counter.
  - ILLEGAL accept → resp_vld_o=1 next cycle with resp_data_o = all ones.
  - resp_vld_o and resp_data_o are held until resp_rdy_i; handshake clears resp_vld_o next cycle.
  - Queue ops never generate a response.
- Channel ordering: no ordering across channels; strict FIFO order within each channel.

Test Plan:
- Reset, then push 3 TLOAD with rs1=0x10,0x20,0x30 while ld_rdy_i=0 → ld_cnt_o=3, ld_vld_o=1, ld_addr0_o=0x10. Raise ld_rdy_i → issues 0x10,0x20,0x30 on consecutive cycles, then ld_vld_o=0.
- Fill ld queue (4 TLOAD) with ld_rdy_i=0 → req_rdy_o=0 for a 5th TLOAD while a TMMA is still accepted (mma_cnt_o=1, mma_type_o=1). Pop one ld entry → next-cycle TLOAD accepted. Continue to 9 pushes/pops to cover pointer wrap-around.
- Empty ld queue: push and issue-ready asserted in the same cycle → ld_vld_o rises only the following cycle. In a full queue, simultaneous push and pop → push rejected, count drops to 3.
- Issue 5 ops total, then FENCE while mma queue holds 1 entry → req_rdy_o=0 until mma drains. Then FENCE accepted → resp_data_o=5 next cycle. Hold resp_rdy_i=0 for 3 cycles → data stable, a second FENCE is not accepted.
- func3=7 → response 0xFFFF_FFFF_FFFF_FFFF, no queue count changes.
- Assert rst with all queues non-empty and a pending response → next cycle all counts 0, all vld outputs 0, resp_vld_o=0, counter 0.
